// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Handles byte/half/word loads (sign/zero extended) and sub-word stores
// via read-modify-write of the containing word.
module dmem_arbiter #(
    parameter int unsigned MEM_WORDS  = 64,
    parameter logic        RESET_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [3:0]  size,
    input  logic [1:0]  uns,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [1:0]  ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned XLEN = 32;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_WRITE  = 2'b10,
        S_RESP   = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   merge_q, merge_d;
    logic [1:0]        ack_q, ack_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    // Candidate grant and its fields, as seen in IDLE
    logic              sel_g;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [XLEN-1:0]   sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic              sel_bad;

    // Lane extraction / merge results from the current memory word
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   merge_val;

    // Round-robin pick and request validity check
    always_comb begin
        sel_g     = (req == 2'b11) ? ~last_q : req[1];
        sel_we    = sel_g ? we[1]         : we[0];
        sel_size  = sel_g ? size[3:2]     : size[1:0];
        sel_uns   = sel_g ? uns[1]        : uns[0];
        sel_addr  = sel_g ? addr[63:32]   : addr[31:0];
        sel_wdata = sel_g ? wdata[63:32]  : wdata[31:0];
        sel_bad   = (sel_size == SZ_RSVD)
                 || ((sel_size == SZ_HALF) && sel_addr[0])
                 || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00))
                 || (sel_addr[31:2] >= 30'(MEM_WORDS));
    end

    // Little-endian lane select, extension and sub-word merge
    always_comb begin
        byte_v    = 8'h00;
        half_v    = 16'h0000;
        load_val  = mem_rd;
        merge_val = mem_rd;
        case (addr_q[1:0])
            2'd0:    byte_v = mem_rd[7:0];
            2'd1:    byte_v = mem_rd[15:8];
            2'd2:    byte_v = mem_rd[23:16];
            default: byte_v = mem_rd[31:24];
        endcase
        half_v = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{~uns_q & byte_v[7]}}, byte_v};
            SZ_HALF: load_val = {{16{~uns_q & half_v[15]}}, half_v};
            default: load_val = mem_rd;
        endcase
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merge_val[7:0]   = wdata_q[7:0];
                2'd1:    merge_val[15:8]  = wdata_q[7:0];
                2'd2:    merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0]  = wdata_q[15:0];
        end
    end

    // Next-state and response logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = sel_g;
                    last_d  = sel_g;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    uns_d   = sel_uns;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (sel_bad) begin
                        err_d          = 1'b1;
                        ack_d[sel_g]   = 1'b1;
                        state_d        = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d      = load_val;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_RESP;
                end else if (size_q == SZ_WORD) begin
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    merge_d = merge_val;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ack_d[gnt_q] = 1'b1;
                state_d      = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= RESET_LAST;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory-side decode; forced low while reset is high so a pending write is dropped
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (!reset) begin
            case (state_q)
                S_ACCESS: begin
                    mem_a = {2'b00, addr_q[31:2]};
                    if (we_q && (size_q == SZ_WORD)) begin
                        mem_we = 1'b1;
                        mem_wd = wdata_q;
                    end
                end
                S_WRITE: begin
                    mem_a  = {2'b00, addr_q[31:2]};
                    mem_we = 1'b1;
                    mem_wd = merge_q;
                end
                default: ;
            endcase
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we, uns;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(64), .RESET_LAST(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // data_memory model: combinational read, write on posedge
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[5:0]] <= mem_wd;
        else if (poke_en) mem[poke_idx] <= poke_data;
    end
    assign mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        poke_en = 1'b1; poke_idx = 6'(idx); poke_data = d;
        tick;
        poke_en = 1'b0;
    endtask

    task automatic set_port(input int n, input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] d);
        if (n == 0) begin
            we[0] = w; size[1:0] = sz; uns[0] = u; addr[31:0] = a; wdata[31:0] = d;
        end else begin
            we[1] = w; size[3:2] = sz; uns[1] = u; addr[63:32] = a; wdata[63:32] = d;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 2'b00;
        repeat (2) tick;
        vectors++; if (ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack got %b want 00", ack); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
        vectors++; if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            miscompares++; $display("FAIL reset_mem we=%b a=%h wd=%h want all 0", mem_we, mem_a, mem_wd); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_load_word;
        poke(5, 32'h11223344);
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        req = 2'b01;
        tick;
        vectors++; if (ack !== 2'b00) begin miscompares++; $display("FAIL ldw_early_ack got %b want 00", ack); end
        vectors++; if (mem_a !== 32'd5) begin miscompares++; $display("FAIL ldw_mem_a got %h want 5", mem_a); end
        tick;
        vectors++; if (ack !== 2'b01) begin miscompares++; $display("FAIL ldw_ack got %b want 01", ack); end
        vectors++; if (rdata !== 32'h11223344 || err !== 1'b0) begin
            miscompares++; $display("FAIL ldw_data got %h err %b want 11223344 err 0", rdata, err); end
        req = 2'b00;
        tick;
        vectors++; if (ack !== 2'b00 || rdata !== 32'h0) begin
            miscompares++; $display("FAIL ldw_clear ack %b rdata %h want 00 0", ack, rdata); end
    endtask

    task automatic test_subword_load;
        set_port(1, 1'b0, 2'b00, 1'b0, 32'h17, 32'h0);
        req = 2'b10;
        repeat (2) tick;
        vectors++; if (ack !== 2'b10 || rdata !== 32'h00000011) begin
            miscompares++; $display("FAIL ldb_s ack %b rdata %h want 10 00000011", ack, rdata); end
        req = 2'b00; tick;
        poke(5, 32'h80001234);
        set_port(1, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
        req = 2'b10;
        repeat (2) tick;
        vectors++; if (ack !== 2'b10 || rdata !== 32'hFFFF8000) begin
            miscompares++; $display("FAIL ldh_s ack %b rdata %h want 10 FFFF8000", ack, rdata); end
        req = 2'b00; tick;
        set_port(1, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        req = 2'b10;
        repeat (2) tick;
        vectors++; if (ack !== 2'b10 || rdata !== 32'h00008000) begin
            miscompares++; $display("FAIL ldh_u ack %b rdata %h want 10 00008000", ack, rdata); end
        req = 2'b00; tick;
        set_port(1, 1'b0, 2'b00, 1'b1, 32'h14, 32'h0);
        req = 2'b10;
        repeat (2) tick;
        vectors++; if (rdata !== 32'h00000034) begin
            miscompares++; $display("FAIL ldb_u0 rdata %h want 00000034", rdata); end
        req = 2'b00; tick;
    endtask

    task automatic test_store;
        poke(6, 32'hAABBCCDD);
        set_port(0, 1'b1, 2'b00, 1'b0, 32'h19, 32'h00000055);
        req = 2'b01;
        tick;
        vectors++; if (mem_we !== 1'b0 || ack !== 2'b00) begin
            miscompares++; $display("FAIL stb_access we %b ack %b want 0 00", mem_we, ack); end
        tick;
        vectors++; if (mem_we !== 1'b1 || mem_a !== 32'd6 || mem_wd !== 32'hAABB55DD || ack !== 2'b00) begin
            miscompares++; $display("FAIL stb_write we %b a %h wd %h ack %b want 1 6 AABB55DD 00",
                                    mem_we, mem_a, mem_wd, ack); end
        tick;
        vectors++; if (ack !== 2'b01 || err !== 1'b0 || rdata !== 32'h0) begin
            miscompares++; $display("FAIL stb_resp ack %b err %b rdata %h want 01 0 0", ack, err, rdata); end
        vectors++; if (mem[6] !== 32'hAABB55DD) begin
            miscompares++; $display("FAIL stb_mem got %h want AABB55DD", mem[6]); end
        req = 2'b00; tick;
        poke(7, 32'h0);
        set_port(1, 1'b1, 2'b10, 1'b0, 32'h1C, 32'hDEADBEEF);
        req = 2'b10;
        tick;
        vectors++; if (mem_we !== 1'b1 || mem_wd !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL stw_access we %b wd %h want 1 DEADBEEF", mem_we, mem_wd); end
        tick;
        vectors++; if (ack !== 2'b10 || mem[7] !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL stw_resp ack %b mem %h want 10 DEADBEEF", ack, mem[7]); end
        req = 2'b00; tick;
        set_port(0, 1'b1, 2'b01, 1'b0, 32'h1E, 32'h0000CAFE);
        req = 2'b01;
        repeat (3) tick;
        vectors++; if (ack !== 2'b01 || mem[7] !== 32'hCAFEBEEF) begin
            miscompares++; $display("FAIL sth_hi ack %b mem %h want 01 CAFEBEEF", ack, mem[7]); end
        req = 2'b00; tick;
    endtask

    task automatic test_fairness;
        logic [1:0]  exp_ack;
        logic [31:0] exp_rd;
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        set_port(1, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        req = 2'b11;
        reset = 1'b1;
        tick;
        vectors++; if (ack !== 2'b00) begin miscompares++; $display("FAIL fair_reset ack %b want 00", ack); end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick;
            exp_ack = 2'b00; exp_rd = 32'h0;
            if (k % 3 == 2) begin
                exp_ack = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
                exp_rd  = ((k / 3) % 2 == 0) ? 32'h80001234 : 32'hAABB55DD;
            end
            vectors++; if (ack !== exp_ack || rdata !== exp_rd) begin
                miscompares++; $display("FAIL fair_cycle%0d ack %b rdata %h want %b %h", k, ack, rdata, exp_ack, exp_rd); end
        end
        req = 2'b00;
        repeat (3) tick;
    endtask

    task automatic test_errors;
        bit saw_we;
        poke(8, 32'h01020304);
        saw_we = 1'b0;
        set_port(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF);
        req = 2'b01;
        if (mem_we) saw_we = 1'b1;
        tick;
        vectors++; if (ack !== 2'b01 || err !== 1'b1 || rdata !== 32'h0) begin
            miscompares++; $display("FAIL err_half ack %b err %b rdata %h want 01 1 0", ack, err, rdata); end
        if (mem_we) saw_we = 1'b1;
        req = 2'b00;
        tick;
        if (mem_we) saw_we = 1'b1;
        vectors++; if (ack !== 2'b00 || err !== 1'b0) begin
            miscompares++; $display("FAIL err_clear ack %b err %b want 00 0", ack, err); end
        vectors++; if (saw_we || mem[8] !== 32'h01020304) begin
            miscompares++; $display("FAIL err_nowrite saw_we %b mem %h want 0 01020304", saw_we, mem[8]); end
        set_port(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        req = 2'b10;
        tick;
        vectors++; if (ack !== 2'b10 || err !== 1'b1) begin
            miscompares++; $display("FAIL err_range ack %b err %b want 10 1", ack, err); end
        req = 2'b00; tick;
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h16, 32'h0);
        req = 2'b01;
        tick;
        vectors++; if (ack !== 2'b01 || err !== 1'b1) begin
            miscompares++; $display("FAIL err_wmis ack %b err %b want 01 1", ack, err); end
        req = 2'b00; tick;
        set_port(1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        req = 2'b10;
        tick;
        vectors++; if (ack !== 2'b10 || err !== 1'b1) begin
            miscompares++; $display("FAIL err_rsvd ack %b err %b want 10 1", ack, err); end
        req = 2'b00; tick;
    endtask

    task automatic test_req_drop;
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        req = 2'b01;
        tick;
        req = 2'b00;
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        tick;
        vectors++; if (ack !== 2'b01 || rdata !== 32'h80001234) begin
            miscompares++; $display("FAIL drop_ack ack %b rdata %h want 01 80001234", ack, rdata); end
        tick;
    endtask

    task automatic test_reset_mid_write;
        poke(9, 32'h12345678);
        set_port(1, 1'b1, 2'b00, 1'b0, 32'h24, 32'h000000AA);
        req = 2'b10;
        repeat (2) tick;
        vectors++; if (mem_we !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre_we got %b want 1", mem_we); end
        reset = 1'b1;
        #1;
        vectors++; if (mem_we !== 1'b0) begin
            miscompares++; $display("FAIL rst_async_we got %b want 0", mem_we); end
        req = 2'b00;
        tick;
        vectors++; if (mem[9] !== 32'h12345678 || ack !== 2'b00) begin
            miscompares++; $display("FAIL rst_nowrite mem %h ack %b want 12345678 00", mem[9], ack); end
        reset = 1'b0;
        tick;
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        set_port(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        req = 2'b11;
        tick;
        vectors++; if (ack !== 2'b00) begin
            miscompares++; $display("FAIL rst_after_early ack %b want 00", ack); end
        tick;
        vectors++; if (ack !== 2'b01 || rdata !== 32'h12345678) begin
            miscompares++; $display("FAIL rst_after_grant ack %b rdata %h want 01 12345678", ack, rdata); end
        req = 2'b00;
        tick;
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; we = 2'b00; size = 4'h0; uns = 2'b00;
        addr = 64'h0; wdata = 64'h0;
        poke_en = 1'b0; poke_idx = 6'd0; poke_data = 32'h0;
        test_reset;
        test_load_word;
        test_subword_load;
        test_store;
        test_fairness;
        test_errors;
        test_req_drop;
        test_reset_mid_write;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
